// File: rtl/mem_path_pkg.sv
// Shared definitions for the memory-stage completion path: opcodes,
// merge FSM states and channel-select encoding.
package mem_path_pkg;

  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_LOAD  = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    RTZ_OUT,
    RTZ_SRC
  } merge_state_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_LD,
    SEL_ST
  } sel_e;

  // True when the accepted channel disagrees with the memory-stage opcode.
  function automatic logic route_mismatch(sel_e sel, logic [OPC_W-1:0] opc);
    return ((sel == SEL_LD) && (opc != OPC_LOAD)) ||
           ((sel == SEL_ST) && (opc != OPC_STORE));
  endfunction

endpackage

// File: rtl/merge_2_s_l_if.sv
// Handshake bundle between the load/store completion sources, the merge
// point and the downstream consumer.
interface merge_2_s_l_if #(
  parameter int unsigned DATA_W = 32
) ();
  import mem_path_pkg::*;

  logic [OPC_W-1:0]  opcode;
  logic              req_1;
  logic [DATA_W-1:0] data_1;
  logic              ack_1;
  logic              req_2;
  logic              ack_2;
  logic              req_out;
  logic [DATA_W-1:0] data_out;
  logic              is_load;
  logic              ack_in;
  logic              err_both;
  logic              err_route;

  // Environment side: sources and downstream consumer.
  modport master (
    output opcode, req_1, data_1, req_2, ack_in,
    input  ack_1, ack_2, req_out, data_out, is_load, err_both, err_route
  );

  // Merge point side.
  modport slave (
    input  opcode, req_1, data_1, req_2, ack_in,
    output ack_1, ack_2, req_out, data_out, is_load, err_both, err_route
  );

endinterface

// File: rtl/sync_ff.sv
// Single-bit flop-chain synchronizer for an asynchronous handshake input.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/merge_2_s_l.sv
// Merges load (channel 1) and store (channel 2) four-phase completions into one
// downstream request, with sticky protocol/routing error flags.
module merge_2_s_l
  import mem_path_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = 32
) (
  input  logic          clk,
  input  logic          rst,
  merge_2_s_l_if.slave  bus
);

  logic s_req_1;
  logic s_req_2;
  logic s_ack_in;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_req_1 (
    .clk(clk), .rst(rst), .d_i(bus.req_1), .q_o(s_req_1)
  );
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_req_2 (
    .clk(clk), .rst(rst), .d_i(bus.req_2), .q_o(s_req_2)
  );
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack_in (
    .clk(clk), .rst(rst), .d_i(bus.ack_in), .q_o(s_ack_in)
  );

  merge_state_e      state_q, state_d;
  sel_e              sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              is_load_q, is_load_d;
  logic              err_both_q, err_both_d;
  logic              err_route_q, err_route_d;
  logic              req_out_q;
  logic              ack_1_q;
  logic              ack_2_q;
  logic              sel_req;

  assign sel_req = (sel_q == SEL_LD) ? s_req_1 : s_req_2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= SEL_NONE;
      data_q      <= '0;
      is_load_q   <= 1'b0;
      err_both_q  <= 1'b0;
      err_route_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      is_load_q   <= is_load_d;
      err_both_q  <= err_both_d;
      err_route_q <= err_route_d;
    end
  end

  // Channel 1 has priority; data_1 is only trusted once s_req_1 is seen high.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    data_d      = data_q;
    is_load_d   = is_load_q;
    err_both_d  = err_both_q;
    err_route_d = err_route_q;
    unique case (state_q)
      IDLE: begin
        if (s_req_1) begin
          sel_d     = SEL_LD;
          data_d    = bus.data_1;
          is_load_d = 1'b1;
          state_d   = FWD;
          if (s_req_2) err_both_d = 1'b1;
          if (route_mismatch(SEL_LD, bus.opcode)) err_route_d = 1'b1;
        end else if (s_req_2) begin
          sel_d     = SEL_ST;
          data_d    = '0;
          is_load_d = 1'b0;
          state_d   = FWD;
          if (route_mismatch(SEL_ST, bus.opcode)) err_route_d = 1'b1;
        end
      end
      FWD: begin
        if (s_ack_in) state_d = RTZ_OUT;
      end
      RTZ_OUT: begin
        if (!s_ack_in && !sel_req) state_d = RTZ_SRC;
      end
      RTZ_SRC: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs follow the registered state one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_out_q <= 1'b0;
      ack_1_q   <= 1'b0;
      ack_2_q   <= 1'b0;
    end else begin
      req_out_q <= (state_q == FWD);
      ack_1_q   <= (state_q == RTZ_OUT) && (sel_q == SEL_LD);
      ack_2_q   <= (state_q == RTZ_OUT) && (sel_q == SEL_ST);
    end
  end

  assign bus.req_out   = req_out_q;
  assign bus.ack_1     = ack_1_q;
  assign bus.ack_2     = ack_2_q;
  assign bus.data_out  = data_q;
  assign bus.is_load   = is_load_q;
  assign bus.err_both  = err_both_q;
  assign bus.err_route = err_route_q;

endmodule

// File: doc/merge_2_s_l.md
# merge_2_s_l

Synchronous merge point that rejoins the load and store completion paths after the memory stage. It accepts a four-phase request from the load path (channel 1) or the store path (channel 2) and forwards it as one four-phase request downstream, with the load data attached. It acknowledges the originating channel only after the downstream side has acknowledged. It also checks the completion against the memory-stage opcode and raises sticky error flags on protocol or routing violations.

## Interface
Parameters:
- SYNC_STAGES, default 2: flops in each handshake-input synchronizer. Legal range is 1 to 3.
- DATA_W, default 32: width of the load data path.

Ports:
- clk  in  1  the single clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  memory-stage opcode, stable while a transaction is pending. 7'b0000011 is load and 7'b0100011 is store.
- req_1  in  1  load-path completion request, four-phase.
- data_1  in  DATA_W  load data, valid while req_1 is high.
- ack_1  out  1  acknowledge to the load path.
- req_2  in  1  store-path completion request, four-phase.
- ack_2  out  1  acknowledge to the store path.
- req_out  out  1  merged request downstream.
- data_out  out  DATA_W  captured load data. Zero for stores.
- is_load  out  1  1 when the current transaction came from channel 1.
- ack_in  in  1  downstream acknowledge.
- err_both  out  1  sticky. Both requests were seen high in the same IDLE cycle.
- err_route  out  1  sticky. The accepted channel does not match the opcode.

## Operation
- req_1, req_2 and ack_in each pass through a SYNC_STAGES-flop synchronizer (s_req_1, s_req_2, s_ack_in). data_1 is sampled only after s_req_1 is high, which is the bundled-data assumption.
- The FSM has four states: IDLE, FWD, RTZ_OUT, RTZ_SRC.
- IDLE:
  - If s_req_1 is high, set sel=1, capture data_1 into data_out, set is_load=1, and go to FWD.
  - Else if s_req_2 is high, set sel=2, set data_out=0, set is_load=0, and go to FWD.
  - If both are high, channel 1 wins and err_both is set.
  - err_route is set on capture if (sel=1 and opcode≠load) or (sel=2 and opcode≠store).
- FWD: req_out=1. When s_ack_in is high, go to RTZ_OUT.
- RTZ_OUT: req_out=0. The selected ack_x rises. When s_ack_in is low and the selected s_req_x is low, go to RTZ_SRC.
- RTZ_SRC: the selected ack_x falls. Go to IDLE.
- The unselected ack is always 0. data_out and is_load hold their value until the next capture.
- Reset values: state=IDLE, req_out=0, ack_1=0, ack_2=0, data_out=0, is_load=0, err_both=0, err_route=0, and all synchronizer flops 0.
- The error flags clear only on rst.

## Timing
- All outputs are registered. There is no combinational path from an input to an output.
- Request-in to req_out high: SYNC_STAGES + 1 cycles from the first clk edge that samples the high request.
- ack_in high to ack_x high: SYNC_STAGES + 1 cycles.
- The source request and ack_in must both return to zero before ack_x falls. A new request is accepted no earlier than the cycle after RTZ_SRC.
- Simultaneous events:
  - If s_ack_in and s_req_x fall in the same cycle in RTZ_OUT, the transition to RTZ_SRC happens on that cycle.
  - A request on the unselected channel during a transaction is ignored until IDLE. It is not an error unless it is still high together with the other request when IDLE is re-entered.
- Reset mid-transaction: the next clk edge with rst high forces IDLE and drops req_out and ack_x. Sources are then required to return to zero before re-requesting. A request still high after reset is treated as a new request.
- If ack_in rises while in IDLE (a protocol violation), it is ignored.

## Structure
- Shared package mem_path_pkg holds:
  - OPC_LOAD and OPC_STORE localparams.
  - The merge state enum (IDLE, FWD, RTZ_OUT, RTZ_SRC).
  - Channel select encoding: SEL_NONE, SEL_LD, SEL_ST.
- Sub-module sync_ff (parameter STAGES, 1-bit) is instantiated three times for the handshake inputs.
- Everything else lives in a single always_ff FSM plus an output register block.

## Test plan
- Load round-trip:
  - Stimulus: opcode=7'b0000011, req_1=1, data_1=32'hDEADBEEF. Downstream acks after req_out.
  - Required: req_out rises 3 cycles later; data_out=DEADBEEF; is_load=1. ack_1 rises 3 cycles after ack_in, and falls after req_1 and ack_in return to 0. Both error flags stay 0.
- Store round-trip:
  - Stimulus: opcode=7'b0100011, req_2=1.
  - Required: req_out=1, data_out=0, is_load=0. ack_2 performs the full four-phase sequence; ack_1 stays 0.
- Simultaneous requests:
  - Stimulus: req_1 and req_2 rise on the same edge.
  - Required: channel 1 is served and err_both=1. After RTZ, channel 2 is served next with err_route=1 (opcode is load).
- Route mismatch:
  - Stimulus: opcode=store, req_1=1.
  - Required: transaction completes normally and err_route=1, staying set until rst.
- Reset mid-transaction:
  - Stimulus: assert rst during FWD.
  - Required: next cycle req_out=0, ack_1=0, state=IDLE. After release with req_1 still high, a fresh transaction starts.
- Back-to-back with SYNC_STAGES=1:
  - Stimulus: two loads, data 32'h1 then 32'h2.
  - Required: the second is captured only after RTZ_SRC; data_out shows 1 then 2; latency is 2 cycles per handshake edge.
